// File: rtl/r200_mem_arb_pkg.sv
// rtl/r200_mem_arb_pkg.sv - shared types and defaults for the r200 memory arbiter
//
// Purpose : FSM state encoding and the default starvation limit used by r200_mem_arb.
// Contents: arb_state_t   - ARB_IDLE / ARB_BUSY_IF / ARB_BUSY_MEM (2 bits)
//           STARVE_MAX_DEFAULT - consecutive MEM grants allowed while fetch waits
package r200_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/r200_mem_arb.sv
// rtl/r200_mem_arb.sv - single-port memory arbiter shared by fetch and the MEM stage
//
// Purpose : Shares one memory bus between instruction fetch (read-only) and the MEM
//           stage (read/write), one transaction outstanding at a time. MEM has priority
//           but after STARVE_MAX consecutive MEM grants with fetch waiting, fetch wins.
// Ports   : clk, rst (synchronous, active-high)
//           if_req/if_addr -> if_gnt (comb), if_rvalid/if_rdata (registered)
//           mem_req/mem_we/mem_addr/mem_wdata -> mem_gnt (comb), mem_rvalid/mem_rdata
//           bus_req/bus_we/bus_addr/bus_wdata -> memory, bus_ack/bus_rdata <- memory
//           arb_conflicts : cycles with both requests pending (only with R200_ARB_PERF_EN)
// Config  : `define R200_ARB_PERF_EN to add the arb_conflicts port and counter.
module r200_mem_arb
    import r200_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef R200_ARB_PERF_EN
    ,
    output logic [31:0] arb_conflicts
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [SW-1:0] starve_cnt;
    logic          starve_full;
    logic          if_win;
    logic          mem_win;

    // Winner among the present requests, independent of FSM state; the
    // grants below qualify it with IDLE and reset.
    assign starve_full = (starve_cnt == SW'(STARVE_MAX));
    assign if_win      = if_req && (!mem_req || starve_full);
    assign mem_win     = mem_req && !if_win;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                if (if_win) begin
                    state_next = ARB_BUSY_IF;
                end else if (mem_win) begin
                    state_next = ARB_BUSY_MEM;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                if (bus_ack) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Output logic: grants are combinational so the requester sees acceptance
    // in the request cycle.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        bus_req = (state != ARB_IDLE);
        if (!rst && state == ARB_IDLE) begin
            if_gnt  = if_win;
            mem_gnt = mem_win;
        end
    end

    // Request capture: bus_* are loaded only at grant, so they stay stable for
    // the whole BUSY phase regardless of what the requesters do afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
        end else if (if_gnt) begin
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= 32'd0;
        end else if (mem_gnt) begin
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
        end
    end

    // Read return: bus_ack only counts in a BUSY state, so a late ack after a
    // reset (or a stray ack in IDLE) never produces rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid  <= 1'b0;
            mem_rvalid <= 1'b0;
            if_rdata   <= 32'd0;
            mem_rdata  <= 32'd0;
        end else begin
            if_rvalid  <= (state == ARB_BUSY_IF) && bus_ack;
            mem_rvalid <= (state == ARB_BUSY_MEM) && bus_ack;
            if ((state == ARB_BUSY_IF) && bus_ack) begin
                if_rdata <= bus_rdata;
            end
            if ((state == ARB_BUSY_MEM) && bus_ack) begin
                mem_rdata <= bus_rdata;
            end
        end
    end

    // Starvation counter: counts MEM grants taken while fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (mem_gnt && !starve_full) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

`ifdef R200_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_conflicts <= 32'd0;
        end else if (if_req && mem_req) begin
            arb_conflicts <= arb_conflicts + 32'd1;
        end
    end
`endif

endmodule
